// File: rtl/ralu_seq_ctrl.sv
// RALU command sequencer: expands one register-level command per start/done
// handshake into per-cycle RALU controls and captures the written-back result.
module ralu_seq_ctrl #(
   parameter logic [5:0] CFG_ADD   = 6'b1001_0_0,
   parameter logic [5:0] CFG_SUB   = 6'b0110_0_1,
   parameter logic [5:0] CFG_AND   = 6'b1011_1_0,
   parameter logic [5:0] CFG_OR    = 6'b1110_1_0,
   parameter logic [5:0] CFG_XOR   = 6'b0110_1_0,
   parameter logic [5:0] CFG_PASSA = 6'b1111_1_0,
   parameter logic [5:0] CFG_PASSB = 6'b1010_1_0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [2:0] ra,
   input  logic [2:0] rb,
   input  logic [2:0] rd,
   input  logic [3:0] imm,
   input  logic [1:0] cnt,
   input  logic       fill,
   output logic       busy,
   output logic       done,
   output logic [3:0] result,
   output logic       carry_out,
   output logic [3:0] ralu_s,
   output logic       ralu_m,
   output logic       ralu_p0,
   output logic       ralu_a,
   output logic [3:0] ralu_v,
   output logic [2:0] ralu_adr,
   output logic       ralu_wr,
   output logic       ralu_isl,
   output logic       ralu_isr,
   output logic [3:0] ralu_datain,
   input  logic [3:0] ralu_r,
   input  logic       ralu_p4
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_LDI = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LDB,
      S_SH,
      S_LDA,
      S_WB
   } state_t;

   state_t     r_state;
   logic [2:0] r_op;
   logic [2:0] r_ra;
   logic [2:0] r_rb;
   logic [2:0] r_rd;
   logic [3:0] r_imm;
   logic [1:0] r_cnt;
   logic       r_fill;
   logic [1:0] r_shcnt;
   logic       r_busy;
   logic       r_done;
   logic [3:0] r_result;
   logic       r_carry;
   logic [5:0] r_cfg;
   logic       r_a;
   logic [3:0] r_v;
   logic [2:0] r_adr;
   logic       r_wr;

   state_t     w_nxt;
   logic [2:0] w_op;
   logic [2:0] w_ra;
   logic [2:0] w_rb;
   logic [2:0] w_rd;
   logic [3:0] w_imm;
   logic [1:0] w_cnt;
   logic       w_fill;
   logic [1:0] w_shcnt;
   logic       w_is_shift;
   logic [5:0] w_cfg;
   logic       w_a;
   logic [3:0] w_v;
   logic [2:0] w_adr;
   logic       w_wr;

   function automatic logic [5:0] cfg_of(input logic [2:0] f_op);
      logic [5:0] c;
      unique case (f_op)
         OP_ADD:  c = CFG_ADD;
         OP_SUB:  c = CFG_SUB;
         OP_AND:  c = CFG_AND;
         OP_OR:   c = CFG_OR;
         OP_XOR:  c = CFG_XOR;
         OP_SHL,
         OP_SHR:  c = CFG_PASSB;
         default: c = CFG_PASSA;
      endcase
      return c;
   endfunction

   assign w_is_shift = (r_op == OP_SHL) || (r_op == OP_SHR);

   // Next state and next latched command fields.
   always_comb begin
      w_nxt   = r_state;
      w_op    = r_op;
      w_ra    = r_ra;
      w_rb    = r_rb;
      w_rd    = r_rd;
      w_imm   = r_imm;
      w_cnt   = r_cnt;
      w_fill  = r_fill;
      w_shcnt = r_shcnt;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_op   = op;
               w_ra   = ra;
               w_rb   = rb;
               w_rd   = rd;
               w_imm  = imm;
               w_cnt  = cnt;
               w_fill = fill;
               w_nxt  = (op == OP_LDI) ? S_LDA : S_LDB;
            end
         end
         S_LDB: begin
            if (!w_is_shift) begin
               w_nxt = S_LDA;
            end else if (r_cnt == 2'd0) begin
               w_nxt = S_WB;
            end else begin
               w_nxt   = S_SH;
               w_shcnt = r_cnt;
            end
         end
         S_SH: begin
            w_shcnt = r_shcnt - 2'd1;
            if (r_shcnt == 2'd1) w_nxt = S_WB;
         end
         S_LDA:   w_nxt = S_WB;
         S_WB:    w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Controls decoded from the state being entered, so they register
   // in step with it and stay stable for the whole cycle.
   always_comb begin
      w_cfg = CFG_PASSA;
      w_a   = 1'b0;
      w_v   = 4'b0000;
      w_adr = 3'd0;
      w_wr  = 1'b0;
      unique case (w_nxt)
         S_LDB: begin
            w_adr = w_rb;
            w_v   = 4'b0110;
         end
         S_SH: begin
            w_adr = w_rb;
            w_v   = (w_op == OP_SHL) ? 4'b0010 : 4'b0100;
         end
         S_LDA: begin
            w_adr = w_ra;
            w_v   = 4'b0001;
            w_a   = (w_op == OP_LDI);
         end
         S_WB: begin
            w_adr = w_rd;
            w_wr  = 1'b1;
            w_cfg = cfg_of(w_op);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_op     <= 3'd0;
         r_ra     <= 3'd0;
         r_rb     <= 3'd0;
         r_rd     <= 3'd0;
         r_imm    <= 4'd0;
         r_cnt    <= 2'd0;
         r_fill   <= 1'b0;
         r_shcnt  <= 2'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 4'd0;
         r_carry  <= 1'b0;
         r_cfg    <= CFG_PASSA;
         r_a      <= 1'b0;
         r_v      <= 4'b0000;
         r_adr    <= 3'd0;
         r_wr     <= 1'b0;
      end else begin
         r_state  <= w_nxt;
         r_op     <= w_op;
         r_ra     <= w_ra;
         r_rb     <= w_rb;
         r_rd     <= w_rd;
         r_imm    <= w_imm;
         r_cnt    <= w_cnt;
         r_fill   <= w_fill;
         r_shcnt  <= w_shcnt;
         r_busy   <= (w_nxt != S_IDLE);
         r_done   <= (r_state == S_WB);
         r_cfg    <= w_cfg;
         r_a      <= w_a;
         r_v      <= w_v;
         r_adr    <= w_adr;
         r_wr     <= w_wr;
         if (r_state == S_WB) begin
            r_result <= ralu_r;
            r_carry  <= ralu_p4;
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign result      = r_result;
   assign carry_out   = r_carry;
   assign ralu_s      = r_cfg[5:2];
   assign ralu_m      = r_cfg[1];
   assign ralu_p0     = r_cfg[0];
   assign ralu_a      = r_a;
   assign ralu_v      = r_v;
   assign ralu_adr    = r_adr;
   assign ralu_wr     = r_wr;
   assign ralu_isl    = r_fill;
   assign ralu_isr    = r_fill;
   assign ralu_datain = r_imm;

endmodule

// File: tb/tb_ralu_seq_ctrl.sv
// Bench for ralu_seq_ctrl: a behavioural RALU closes the loop, and each
// command is checked against register-level arithmetic on a model file.
module tb_ralu_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] op, ra, rb, rd;
   logic [3:0] imm;
   logic [1:0] cnt;
   logic       fill;
   logic       busy, done, carry_out;
   logic [3:0] result;
   logic [3:0] ralu_s;
   logic       ralu_m, ralu_p0, ralu_a;
   logic [3:0] ralu_v;
   logic [2:0] ralu_adr;
   logic       ralu_wr, ralu_isl, ralu_isr;
   logic [3:0] ralu_datain;
   logic [3:0] ralu_r;
   logic       ralu_p4;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ralu_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .op(op), .ra(ra), .rb(rb), .rd(rd),
      .imm(imm), .cnt(cnt), .fill(fill),
      .busy(busy), .done(done),
      .result(result), .carry_out(carry_out),
      .ralu_s(ralu_s), .ralu_m(ralu_m),
      .ralu_p0(ralu_p0), .ralu_a(ralu_a),
      .ralu_v(ralu_v), .ralu_adr(ralu_adr),
      .ralu_wr(ralu_wr), .ralu_isl(ralu_isl),
      .ralu_isr(ralu_isr), .ralu_datain(ralu_datain),
      .ralu_r(ralu_r), .ralu_p4(ralu_p4)
   );

   // Behavioural RALU: RgA, RgB, 8x4 register file, ALU.
   logic [3:0] m_rga, m_rgb;
   logic [3:0] m_rf [8];
   logic       m_clr;
   int         wr_cnt;
   logic [4:0] m_sum;

   always_comb begin
      m_sum = 5'd0;
      case ({ralu_m, ralu_s})
         5'b0_1001: m_sum = {1'b0, m_rga} + {1'b0, m_rgb} + {4'd0, ralu_p0};
         5'b0_0110: m_sum = {1'b0, m_rga} + {1'b0, ~m_rgb} + {4'd0, ralu_p0};
         5'b1_1011: m_sum = {1'b0, m_rga & m_rgb};
         5'b1_1110: m_sum = {1'b0, m_rga | m_rgb};
         5'b1_0110: m_sum = {1'b0, m_rga ^ m_rgb};
         5'b1_1111: m_sum = {1'b0, m_rga};
         5'b1_1010: m_sum = {1'b0, m_rgb};
         default:   m_sum = 5'd0;
      endcase
   end
   assign ralu_r  = m_sum[3:0];
   assign ralu_p4 = m_sum[4];

   always @(posedge clk) begin
      if (m_clr) begin
         for (int i = 0; i < 8; i++) m_rf[i] <= 4'd0;
         m_rga  <= 4'd0;
         m_rgb  <= 4'd0;
         wr_cnt <= 0;
      end else begin
         if (ralu_v[0]) m_rga <= ralu_a ? ralu_datain : m_rf[ralu_adr];
         case (ralu_v[2:1])
            2'b11: m_rgb <= m_rf[ralu_adr];
            2'b01: m_rgb <= {m_rgb[2:0], ralu_isl};
            2'b10: m_rgb <= {ralu_isr, m_rgb[3:1]};
            default: ;
         endcase
         if (ralu_wr) begin
            m_rf[ralu_adr] <= ralu_r;
            wr_cnt <= wr_cnt + 1;
         end
      end
   end

   // Reference register file, updated per command.
   int ref_rf [8];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void ref_exec(input int f_op, f_ra, f_rb, f_rd,
                                    input int f_imm, f_cnt, f_fill,
                                    output int er, output int ec,
                                    output int nb);
      int a, b;
      a  = ref_rf[f_ra];
      b  = ref_rf[f_rb];
      ec = 0;
      nb = 3;
      case (f_op)
         0: begin er = (a + b) % 16; ec = (a + b >= 16) ? 1 : 0; end
         1: begin er = (a - b + 16) % 16; ec = (a >= b) ? 1 : 0; end
         2: er = a & b;
         3: er = a | b;
         4: er = a ^ b;
         5: begin
            er = ((b << f_cnt) | (f_fill != 0 ? (1 << f_cnt) - 1 : 0)) & 15;
            nb = 2 + f_cnt;
         end
         6: begin
            er = (b >> f_cnt) | (f_fill != 0 ? (15 << (4 - f_cnt)) & 15 : 0);
            nb = 2 + f_cnt;
         end
         default: begin er = f_imm; nb = 2; end
      endcase
      ref_rf[f_rd] = er;
   endfunction

   task automatic run_cmd(input int c_op, c_ra, c_rb, c_rd,
                          input int c_imm, c_cnt, c_fill, c_hold);
      int er, ec, nb, n, wr0;
      ref_exec(c_op, c_ra, c_rb, c_rd, c_imm, c_cnt, c_fill, er, ec, nb);
      wr0   = wr_cnt;
      op    = 3'(c_op);
      ra    = 3'(c_ra);
      rb    = 3'(c_rb);
      rd    = 3'(c_rd);
      imm   = 4'(c_imm);
      cnt   = 2'(c_cnt);
      fill  = c_fill[0];
      start = 1'b1;
      @(negedge clk);
      chk("done_pulse", done, 0);
      n = 0;
      while (busy && n < 20) begin
         n++;
         start = c_hold[0];
         if (c_hold != 0) begin
            op  = 3'($urandom);
            ra  = 3'($urandom);
            rb  = 3'($urandom);
            rd  = 3'($urandom);
            imm = 4'($urandom);
            cnt = 2'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", n, nb);
      chk("done", done, 1);
      chk("result", result, er);
      chk("carry", carry_out, ec);
      chk("rf_rd", m_rf[c_rd], er);
      chk("wr_count", wr_cnt - wr0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int keep, wr0;
      reset = 1'b1;
      m_clr = 1'b1;
      start = 1'b0;
      op = 0; ra = 0; rb = 0; rd = 0;
      imm = 0; cnt = 0; fill = 0;
      for (int i = 0; i < 8; i++) ref_rf[i] = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_v", ralu_v, 0);
      chk("rst_wr", ralu_wr, 0);
      reset = 1'b0;
      m_clr = 1'b0;
      @(negedge clk);

      run_cmd(7, 0, 0, 1, 5, 0, 0, 0);
      run_cmd(7, 0, 0, 2, 3, 0, 0, 0);
      run_cmd(0, 1, 2, 3, 0, 0, 0, 0);
      run_cmd(5, 0, 1, 4, 0, 2, 1, 0);
      run_cmd(6, 0, 1, 5, 0, 0, 1, 1);
      run_cmd(7, 0, 0, 6, 15, 0, 0, 0);
      run_cmd(7, 0, 0, 7, 1, 0, 0, 0);
      run_cmd(0, 6, 7, 0, 0, 0, 0, 0);
      run_cmd(1, 7, 6, 0, 0, 0, 0, 0);
      run_cmd(6, 0, 6, 3, 0, 3, 0, 0);

      for (int k = 0; k < 60; k++) begin
         run_cmd($urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      // Abort an ADD in its LDA cycle: destination must stay untouched.
      keep  = ref_rf[3];
      wr0   = wr_cnt;
      op    = 3'd0;
      ra    = 3'd6;
      rb    = 3'd7;
      rd    = 3'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_in_lda", ralu_v, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 0);
      chk("abort_carry", carry_out, 0);
      chk("abort_v", ralu_v, 0);
      chk("abort_wr", ralu_wr, 0);
      repeat (3) @(negedge clk);
      chk("abort_idle", busy, 0);
      chk("abort_rd", m_rf[3], keep);
      chk("abort_wrcnt", wr_cnt - wr0, 0);

      run_cmd(3, 1, 2, 4, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
